// File: rtl/trig_msg_gen_if.sv
// Message stream carried from trig_msg_gen to its consumer (ready/valid).
interface trig_msg_gen_if;
   localparam int unsigned DATA_W = 32;

   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/trig_msg_gen.sv
// Trigger message generator: coalesces per-beam trigger activity over a
// programmable window into one timestamped message, then enforces a hold-off.
module trig_msg_gen #(
   parameter int unsigned NBEAMS = 2
) (
   input  logic              ifclk,
   input  logic              ifclk_rst_i,
   input  logic [NBEAMS-1:0] trig_i,
   input  logic [NBEAMS-1:0] beam_mask_i,
   input  logic              enable_i,
   input  logic [3:0]        window_i,
   input  logic [7:0]        holdoff_i,
   input  logic              ts_clear_i,
   input  logic              drop_clr_i,
   trig_msg_gen_if.master    m,
   output logic [15:0]       dropped_o,
   output logic [15:0]       msg_count_o
);
   localparam int unsigned TS_W  = 16;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned WIN_W = 4;
   localparam int unsigned HO_W  = 8;

   typedef enum logic [1:0] {IDLE, COLLECT, SEND, HOLDOFF} state_t;

   state_t            state;
   logic [TS_W-1:0]   ts;
   logic [TS_W-1:0]   tstamp;
   logic [NBEAMS-1:0] mtrig;
   logic [NBEAMS-1:0] mtrig_q;
   logic [NBEAMS-1:0] trig_edge;
   logic [NBEAMS-1:0] beams;
   logic [WIN_W-1:0]  wcnt;
   logic [HO_W-1:0]   hcnt;
   logic              busy_out;

   assign mtrig     = trig_i & ~beam_mask_i;
   assign trig_edge = mtrig & ~mtrig_q;
   assign busy_out  = (state == SEND) || (state == HOLDOFF);

   // Free-running timestamp and one-cycle trigger history for edge detection.
   always_ff @(posedge ifclk or posedge ifclk_rst_i) begin
      if (ifclk_rst_i) begin
         ts      <= '0;
         mtrig_q <= '0;
      end else begin
         ts      <= ts_clear_i ? '0 : ts + TS_W'(1);
         mtrig_q <= mtrig;
      end
   end

   // Lost-trigger counter: saturates, and a clear beats a coincident increment.
   always_ff @(posedge ifclk or posedge ifclk_rst_i) begin
      if (ifclk_rst_i) begin
         dropped_o <= '0;
      end else if (drop_clr_i) begin
         dropped_o <= '0;
      end else if (busy_out && (|trig_edge) && (dropped_o != '1)) begin
         dropped_o <= dropped_o + CNT_W'(1);
      end
   end

   // Message FSM: capture, coalesce for window_i+1 cycles, send, then hold off.
   always_ff @(posedge ifclk or posedge ifclk_rst_i) begin
      if (ifclk_rst_i) begin
         state       <= IDLE;
         m.tvalid    <= 1'b0;
         m.tdata     <= '0;
         msg_count_o <= '0;
         beams       <= '0;
         tstamp      <= '0;
         wcnt        <= '0;
         hcnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (enable_i && (|mtrig)) begin
                  state  <= COLLECT;
                  beams  <= mtrig;
                  tstamp <= ts;
                  wcnt   <= window_i;
               end
            end
            COLLECT: begin
               beams <= beams | mtrig;
               if (wcnt == '0) begin
                  state    <= SEND;
                  m.tvalid <= 1'b1;
                  m.tdata  <= {tstamp, TS_W'(beams | mtrig)};
               end else begin
                  wcnt <= wcnt - WIN_W'(1);
               end
            end
            SEND: begin
               if (m.tready) begin
                  m.tvalid    <= 1'b0;
                  msg_count_o <= msg_count_o + CNT_W'(1);
                  if (holdoff_i == '0) begin
                     state <= IDLE;
                  end else begin
                     state <= HOLDOFF;
                     hcnt  <= holdoff_i;
                  end
               end
            end
            HOLDOFF: begin
               // hcnt never reaches 0 here; <= 1 keeps the exit robust anyway.
               if (hcnt <= HO_W'(1)) begin
                  state <= IDLE;
               end else begin
                  hcnt <= hcnt - HO_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_trig_msg_gen.sv
// Bench for trig_msg_gen: directed table, corner-case sequences and random
// stimulus, all checked against a timeline-based reference model.
module tb_trig_msg_gen;
   localparam int unsigned NB = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NB-1:0] trig = '0;
   logic [NB-1:0] mask = '0;
   logic          en = 1'b0;
   logic [3:0]    win = '0;
   logic [7:0]    hold = '0;
   logic          tsclr = 1'b0;
   logic          dclr = 1'b0;
   logic [15:0]   dropped;
   logic [15:0]   msg_count;

   // Pending configuration, applied to the DUT at the start of the next cycle.
   logic [NB-1:0] p_mask = '0;
   logic          p_en = 1'b0;
   logic [3:0]    p_win = '0;
   logic [7:0]    p_hold = '0;
   logic          p_tsclr = 1'b0;
   logic          p_dclr = 1'b0;
   logic          p_rdy = 1'b0;

   int tests = 0;
   int fails = 0;

   trig_msg_gen_if mif ();

   trig_msg_gen #(.NBEAMS(NB)) dut (
      .ifclk       (clk),
      .ifclk_rst_i (rst),
      .trig_i      (trig),
      .beam_mask_i (mask),
      .enable_i    (en),
      .window_i    (win),
      .holdoff_i   (hold),
      .ts_clear_i  (tsclr),
      .drop_clr_i  (dclr),
      .m           (mif),
      .dropped_o   (dropped),
      .msg_count_o (msg_count)
   );

   always #5 clk = ~clk;

   // Reference model: a message is a timeline (capture, first send cycle,
   // accept cycle, first free cycle) rather than a state machine.
   int unsigned   t_now = 0;
   bit            m_busy = 0;
   bit            m_acc = 0;
   int unsigned   m_send_t = 0;
   int unsigned   m_free_t = 0;
   logic [NB-1:0] m_beams = '0;
   logic [15:0]   m_stamp = '0;
   logic [15:0]   m_ts = '0;
   logic [NB-1:0] m_trig_q = '0;
   int unsigned   m_drop = 0;
   logic [15:0]   m_msg = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_acc = 0; m_beams = '0; m_stamp = '0; m_ts = '0;
      m_trig_q = '0; m_drop = 0; m_msg = '0;
   endtask

   // Advance the model across the coming rising edge using the driven inputs.
   task automatic model_step();
      logic [NB-1:0] mt;
      logic [NB-1:0] ed;
      mt = trig & ~mask;
      ed = mt & ~m_trig_q;
      if (!m_busy) begin
         if (en && (mt != '0)) begin
            m_busy   = 1;
            m_acc    = 0;
            m_send_t = t_now + 32'(win) + 2;
            m_beams  = mt;
            m_stamp  = m_ts;
         end
      end else if (t_now < m_send_t) begin
         m_beams = m_beams | mt;
      end else begin
         if ((ed != '0) && (m_drop < 65535)) m_drop++;
         if (!m_acc && mif.tready) begin
            m_acc    = 1;
            m_msg    = m_msg + 16'd1;
            m_free_t = t_now + 1 + 32'(hold);
         end
         if (m_acc && (t_now + 1 >= m_free_t)) m_busy = 0;
      end
      if (dclr) m_drop = 0;
      m_ts     = tsclr ? 16'd0 : m_ts + 16'd1;
      m_trig_q = mt;
      t_now++;
   endtask

   // Compare the DUT outputs of the current cycle with the model.
   task automatic sample();
      bit exp_valid;
      @(negedge clk);
      exp_valid = m_busy && (t_now >= m_send_t) && !m_acc;
      chk("tvalid", 32'(mif.tvalid), 32'(exp_valid));
      if (exp_valid) chk("tdata", mif.tdata, {m_stamp, 14'd0, m_beams});
      chk("dropped", 32'(dropped), m_drop);
      chk("msg_count", 32'(msg_count), 32'(m_msg));
   endtask

   task automatic apply_cfg();
      mask = p_mask; en = p_en; win = p_win; hold = p_hold;
      tsclr = p_tsclr; dclr = p_dclr; mif.tready = p_rdy;
   endtask

   task automatic drive(input logic [NB-1:0] tr);
      trig = tr;
      apply_cfg();
      model_step();
   endtask

   task automatic cyc(input logic [NB-1:0] tr);
      sample();
      drive(tr);
   endtask

   // Asynchronous reset between clock edges, then release at a falling edge.
   task automatic do_reset(input logic [NB-1:0] tr);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_tvalid", 32'(mif.tvalid), 32'd0);
      chk("rst_tdata", mif.tdata, 32'd0);
      chk("rst_dropped", 32'(dropped), 32'd0);
      chk("rst_msg_count", 32'(msg_count), 32'd0);
      model_reset();
      trig = tr;
      apply_cfg();
      @(negedge clk);
      rst = 1'b0;
      model_step();
   endtask

   typedef struct {
      logic [NB-1:0] trig;
      logic          exp_valid;
      logic [31:0]   exp_data;
      logic [15:0]   exp_msg;
   } vec_t;

   vec_t tbl [20];

   initial begin
      mif.tready = 1'b0;

      // Two pulses on different beams inside one window: one merged message.
      for (int i = 0; i < 20; i++) begin
         tbl[i].trig      = '0;
         tbl[i].exp_valid = 1'b0;
         tbl[i].exp_data  = '0;
         tbl[i].exp_msg   = (i >= 16) ? 16'd1 : 16'd0;
      end
      tbl[10].trig      = 2'b01;
      tbl[12].trig      = 2'b10;
      tbl[15].exp_valid = 1'b1;
      tbl[15].exp_data  = 32'h000B_0003;

      p_en = 1; p_mask = '0; p_win = 4'd3; p_hold = '0; p_rdy = 1;
      do_reset('0);
      for (int i = 0; i < 20; i++) begin
         sample();
         chk("tbl_tvalid", 32'(mif.tvalid), 32'(tbl[i].exp_valid));
         if (tbl[i].exp_valid) chk("tbl_tdata", mif.tdata, tbl[i].exp_data);
         chk("tbl_msg_count", 32'(msg_count), 32'(tbl[i].exp_msg));
         drive(tbl[i].trig);
      end

      // Masked beam never produces a message or a drop.
      p_mask = 2'b01; p_win = 4'd0;
      do_reset('0);
      for (int i = 0; i < 5; i++) begin cyc(2'b01); cyc(2'b00); end
      cyc('0); cyc('0);
      chk("mask_tvalid", 32'(mif.tvalid), 32'd0);
      chk("mask_dropped", 32'(dropped), 32'd0);
      chk("mask_msg", 32'(msg_count), 32'd0);

      // Backpressure: data held, three edges in SEND dropped, one message.
      p_mask = '0; p_win = 4'd0; p_hold = '0; p_rdy = 0;
      do_reset('0);
      cyc(2'b01); cyc(2'b00);
      for (int k = 0; k < 20; k++) cyc((k == 2 || k == 4 || k == 6) ? 2'b10 : 2'b00);
      chk("bp_tvalid", 32'(mif.tvalid), 32'd1);
      chk("bp_tdata", mif.tdata, 32'h0001_0001);
      chk("bp_dropped", 32'(dropped), 32'd3);
      p_rdy = 1;
      cyc('0); cyc('0);
      chk("bp_msg", 32'(msg_count), 32'd1);
      chk("bp_tvalid_after", 32'(mif.tvalid), 32'd0);

      // Hold-off of 5: edge inside it is dropped, next capture right after.
      p_hold = 8'd5;
      do_reset('0);
      cyc(2'b01); cyc('0); cyc('0); cyc('0); cyc(2'b01); cyc('0);
      chk("ho_dropped", 32'(dropped), 32'd1);
      cyc('0); cyc('0); cyc(2'b01); cyc(2'b01);
      chk("ho_tvalid_early", 32'(mif.tvalid), 32'd0);
      cyc('0);
      chk("ho_tvalid", 32'(mif.tvalid), 32'd1);
      chk("ho_tdata", mif.tdata, 32'h0009_0001);

      // Drop counter saturation, then clear coinciding with an edge.
      p_hold = '0; p_rdy = 0;
      do_reset('0);
      cyc(2'b01); cyc(2'b00);
      for (int i = 0; i < 65540; i++) cyc((i % 2 == 0) ? 2'b01 : 2'b10);
      chk("sat_dropped", 32'(dropped), 32'h0000_FFFF);
      p_dclr = 1;
      cyc(2'b01);
      p_dclr = 0;
      cyc('0);
      chk("clr_dropped", 32'(dropped), 32'd0);

      // Reset while a message is pending; trigger held through release.
      p_win = 4'd1; p_rdy = 1;
      do_reset('0);
      cyc(2'b01); cyc('0); cyc('0); cyc('0);
      p_rdy = 0;
      cyc(2'b10); cyc('0); cyc('0); cyc(2'b01); cyc('0);
      chk("pre_rst_tvalid", 32'(mif.tvalid), 32'd1);
      chk("pre_rst_dropped", 32'(dropped), 32'd1);
      chk("pre_rst_msg", 32'(msg_count), 32'd1);
      do_reset(2'b11);
      cyc(2'b11); cyc(2'b11); cyc(2'b11);
      chk("post_rst_tvalid", 32'(mif.tvalid), 32'd1);
      chk("post_rst_tdata", mif.tdata, 32'h0000_0003);
      p_rdy = 1;
      cyc('0); cyc('0);

      // Random traffic against the model.
      do_reset('0);
      for (int i = 0; i < 4000; i++) begin
         p_en    = ($urandom_range(0, 9) != 0);
         p_mask  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         p_win   = 4'($urandom_range(0, 15));
         p_hold  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 8));
         p_tsclr = ($urandom_range(0, 39) == 0);
         p_dclr  = ($urandom_range(0, 49) == 0);
         p_rdy   = ($urandom_range(0, 9) < 6);
         cyc(($urandom_range(0, 1) == 0) ? trig : 2'($urandom_range(0, 3)));
      end
      sample();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
